// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch codes, fetch states and the
// bit positions of the instruction fields used by the fetch unit.
package cpu_pkg;

    // Opcodes carried in ir[15:12]
    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BLT  = 4'h5;
    localparam logic [3:0] OP_BGT  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Branch condition codes produced by control
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_GT   = 2'b10;
    localparam logic [1:0] BR_LT   = 2'b11;

    // Instruction field positions
    localparam int OP_LSB        = 12;
    localparam int FUNC_LSB      = 0;
    localparam int JMP_OFF_BITS  = 12;
    localparam int BR_OFF_BITS   = 8;

    // Fetch sequencing states
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request bus between the fetch unit and instruction memory.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int INST_WIDTH = 16
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  imem_err;

    // Fetch unit side issues requests
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        input  imem_err
    );

    // Memory side answers requests
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, jump or taken-branch target,
// plus a flag for targets outside instruction memory.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH           = 16,
    parameter int                    INST_WIDTH           = 16,
    parameter int                    BRANCH_CONTROL_WIDTH = 2,
    parameter logic [ADDR_WIDTH-1:0] IMEM_BYTES           = 16'h0100
) (
    input  logic [ADDR_WIDTH-1:0]           pc,
    input  logic [INST_WIDTH-1:0]           ir,
    input  logic                            jump,
    input  logic [BRANCH_CONTROL_WIDTH-1:0] branch,
    input  logic                            cmp_lt,
    input  logic                            cmp_gt,
    input  logic                            cmp_eq,
    output logic [ADDR_WIDTH-1:0]           next_pc,
    output logic                            out_of_range
);
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] jump_off;
    logic [ADDR_WIDTH-1:0] br_off;
    logic                  taken;

    // Offsets are sign-extended and pre-shifted; the top sign bit falls off the shift
    assign seq_pc   = pc + ADDR_WIDTH'(2);
    assign jump_off = {{(ADDR_WIDTH-JMP_OFF_BITS-1){ir[JMP_OFF_BITS-1]}}, ir[JMP_OFF_BITS-1:0], 1'b0};
    assign br_off   = {{(ADDR_WIDTH-BR_OFF_BITS-1){ir[BR_OFF_BITS-1]}}, ir[BR_OFF_BITS-1:0], 1'b0};

    assign taken = ((branch == BR_LT) && cmp_lt) ||
                   ((branch == BR_GT) && cmp_gt) ||
                   ((branch == BR_EQ) && cmp_eq);

    // Jump has priority over a taken branch
    always_comb begin
        next_pc = seq_pc;
        if (jump) begin
            next_pc = seq_pc + jump_off;
        end else if (taken) begin
            next_pc = seq_pc + br_off;
        end
    end

    // Wrapped targets land at high addresses, so one compare covers them too
    assign out_of_range = (next_pc >= IMEM_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing for the multi-cycle CPU: owns the PC,
// the instruction register and the instruction memory handshake.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH           = 16,
    parameter int                    INST_WIDTH           = 16,
    parameter int                    OP_CODE_WIDTH        = 4,
    parameter int                    FUNCTION_CODE_WIDTH  = 4,
    parameter int                    BRANCH_CONTROL_WIDTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC             = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] IMEM_BYTES           = 16'h0100
) (
    input  logic                            clk,
    input  logic                            rst,
    fetch_unit_if.master                    imem,
    output logic [OP_CODE_WIDTH-1:0]        op_code,
    output logic [FUNCTION_CODE_WIDTH-1:0]  func_code,
    output logic [INST_WIDTH-1:0]           instr,
    output logic                            inst_valid,
    input  logic                            jump,
    input  logic                            halt,
    input  logic [BRANCH_CONTROL_WIDTH-1:0] branch,
    input  logic                            cmp_lt,
    input  logic                            cmp_gt,
    input  logic                            cmp_eq,
    input  logic                            ex_stall,
    output logic                            inst_memory_exception,
    output logic                            halted,
    output logic [ADDR_WIDTH-1:0]           pc
);
    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_WIDTH-1:0] ir_q, ir_d;
    logic                  exc_q, exc_d;
    logic                  armed_q;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  out_of_range;

    next_pc_calc #(
        .ADDR_WIDTH           (ADDR_WIDTH),
        .INST_WIDTH           (INST_WIDTH),
        .BRANCH_CONTROL_WIDTH (BRANCH_CONTROL_WIDTH),
        .IMEM_BYTES           (IMEM_BYTES)
    ) u_next_pc_calc (
        .pc           (pc_q),
        .ir           (ir_q),
        .jump         (jump),
        .branch       (branch),
        .cmp_lt       (cmp_lt),
        .cmp_gt       (cmp_gt),
        .cmp_eq       (cmp_eq),
        .next_pc      (next_pc),
        .out_of_range (out_of_range)
    );

    // State registers; armed_q keeps the request low for one cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            exc_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            exc_q   <= exc_d;
            armed_q <= 1'b1;
        end
    end

    // Next-state and handshake outputs for the fetch/execute sequencer
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        exc_d         = exc_q;
        imem.imem_req = 1'b0;
        inst_valid    = 1'b0;
        halted        = 1'b0;
        case (state_q)
            FETCH: begin
                imem.imem_req = armed_q;
                if (armed_q && imem.imem_ready) begin
                    if (imem.imem_err) begin
                        exc_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        ir_d    = imem.imem_rdata;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (halt) begin
                    state_d = HALTED;
                end else if (!ex_stall) begin
                    if (out_of_range) begin
                        exc_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem.imem_addr        = pc_q;
    assign pc                    = pc_q;
    assign instr                 = ir_q;
    assign op_code               = ir_q[OP_LSB +: OP_CODE_WIDTH];
    assign func_code             = ir_q[FUNC_LSB +: FUNCTION_CODE_WIDTH];
    assign inst_memory_exception = exc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing unit for the multi-cycle CPU.
- Owns the PC and the instruction memory request handshake.
- Holds the fetched word and presents `op_code`/`func_code` to the combinational control decoder.
- Consumes the decoder's `jump`, `branch` and `halt` outputs to select the next PC.
- Produces `inst_memory_exception`, which the decoder turns into `halt`.
- One instruction is in flight at a time; there is no overlap between fetch and execute.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, byte-address width of the PC and instruction memory bus.
- `INST_WIDTH`, 16, instruction word width.
- `OP_CODE_WIDTH`, 4, opcode field width, taken from `ir[15:12]`.
- `FUNCTION_CODE_WIDTH`, 4, function field width, taken from `ir[3:0]`.
- `BRANCH_CONTROL_WIDTH`, 2, width of the branch code from control.
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `IMEM_BYTES`, 16'h0100, size of instruction memory; PC values at or above this are illegal.

Ports (clock and reset first):
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: fetch request.
- `imem_addr` output ADDR_WIDTH: fetch byte address; always equals `pc`.
- `imem_ready` input 1: memory has returned data (or an error) this cycle.
- `imem_rdata` input INST_WIDTH: instruction word, valid when `imem_ready`.
- `imem_err` input 1: bus error, qualified by `imem_ready`.
- `op_code` output OP_CODE_WIDTH: `ir[15:12]`, routed to control.
- `func_code` output FUNCTION_CODE_WIDTH: `ir[3:0]`, routed to control.
- `instr` output INST_WIDTH: full instruction register, routed to the register file and immediate fields.
- `inst_valid` output 1: `ir` holds the instruction currently executing.
- `jump` input 1: from control.
- `halt` input 1: from control.
- `branch` input BRANCH_CONTROL_WIDTH: from control. Codes: 11=BLT, 10=BGT, 01=BEQ, 00=none.
- `cmp_lt`, `cmp_gt`, `cmp_eq` input 1 each: register comparison flags from the datapath.
- `ex_stall` input 1: datapath is not finished with the current instruction.
- `inst_memory_exception` output 1: sticky fetch exception.
- `halted` output 1: the unit is in the HALTED state.
- `pc` output ADDR_WIDTH: address of the current instruction (for debug).

## Operation
State machine states: FETCH, EXEC, HALTED.

- **Reset:**
  - `pc` = RESET_PC, `ir` = 0, state = FETCH.
  - `imem_req`, `inst_valid`, `inst_memory_exception` and `halted` are all 0 in the cycle after reset.
  - `imem_req` rises one cycle after `rst` falls.
- **FETCH:**
  - `imem_req` = 1 and is held until `imem_ready`.
  - On `imem_ready` with `!imem_err`: `ir <= imem_rdata`, go to EXEC.
  - On `imem_ready` with `imem_err`: set the exception, go to HALTED.
- **EXEC:**
  - `inst_valid` = 1, `imem_req` = 0.
  - Priority, highest first:
    1. `halt`: go to HALTED, `pc` unchanged. This wins over `ex_stall`.
    2. `ex_stall`: stay in EXEC, nothing changes.
    3. Otherwise: load `pc <= next_pc`, go to FETCH.
- **next_pc** (all arithmetic modulo 2^ADDR_WIDTH):
  - `jump`: `pc + 2 + (sext(ir[11:0]) << 1)`.
  - Branch taken: `pc + 2 + (sext(ir[7:0]) << 1)`.
    - Taken = (`branch`==11 & `cmp_lt`) | (`branch`==10 & `cmp_gt`) | (`branch`==01 & `cmp_eq`).
  - Otherwise: `pc + 2`.
  - If both `jump` and a taken branch are present, `jump` wins.
- **Range check:**
  - A `next_pc` ≥ IMEM_BYTES, including wrap-around to a high address, does not load `pc`.
  - Instead it sets `inst_memory_exception` and the unit goes to HALTED.
  - A misaligned address cannot occur, because every target is even by construction.
- **HALTED:**
  - `imem_req` = 0, `inst_valid` = 0, `halted` = 1.
  - `inst_memory_exception` holds its value.
  - Only `rst` exits this state.

## Timing
- Fetch latency: `inst_valid` rises on the edge that samples `imem_ready`; `ir` is valid in the following cycle.
- Best case is 2 cycles per instruction: 1 FETCH with same-cycle ready, plus 1 EXEC.
- Control is combinational, so `jump`, `branch` and `halt` are sampled in the same EXEC cycle that presents `op_code`.
- `imem_addr` is stable for the whole request. `imem_rdata` is ignored when `imem_ready` is 0.
- `inst_memory_exception` rises on the same edge as the entry to HALTED.
- Reset mid-FETCH aborts the request: `imem_req` = 0 on the next cycle, then a new fetch starts from RESET_PC.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (ALU, LW, SW, BLT, BGT, BEQ, JMP, HALT);
  - branch codes BR_NONE/BR_EQ/BR_GT/BR_LT;
  - the fetch state enum;
  - the instruction field positions.
- One combinational sub-module, `next_pc_calc`, computes the taken decision, the target, and the out-of-range flag.

## Test plan
- **Sequential fetch.** Reset; memory returns 16'h0ABF at 0x00 with 2 wait cycles → `op_code`=0, `func_code`=F, `inst_valid` for 1 cycle, next `imem_addr`=0x02.
- **BEQ.** At pc 0x10, `ir[7:0]`=0xFE, `branch`=01:
  - with `cmp_eq`=1 → next fetch at 0x0E;
  - with `cmp_eq`=0 → next fetch at 0x12.
- **JMP.** `ir`=16'hC010 at pc 0x20, `jump`=1 → next fetch at 0x42.
- **Stall and halt priority.**
  - `ex_stall`=1 for 3 cycles → `pc` and `ir` are frozen and `inst_valid` stays 1.
  - Then `halt`=1 together with `ex_stall`=1 → `halted`=1 on the next cycle.
- **Bus error.** `imem_ready`=1 with `imem_err`=1 → `inst_memory_exception`=1, `halted`=1 and `imem_req`=0 from the next cycle until `rst`.
- **Out-of-range target and reset recovery.**
  - Jump target 0x0100 with IMEM_BYTES=0x100 → exception and HALTED, `pc` unchanged.
  - Then assert `rst` mid-FETCH → `imem_req`=0 for one cycle, then a fetch at 0x00.
